// File: rtl/md_scheduler_if.sv
// E-stage multiply/divide request and HI/LO result bundle for md_scheduler.
interface md_scheduler_if;
  logic [2:0]  E_MD_Op;
  logic        E_Start;
  logic [31:0] E_SrcA;
  logic [31:0] E_SrcB;
  logic        D_MD_Use;
  logic        MD_Busy;
  logic        MD_Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_MD_Op, E_Start, E_SrcA, E_SrcB, D_MD_Use,
    input  MD_Busy, MD_Stall, HI, LO
  );

  modport slave (
    input  E_MD_Op, E_Start, E_SrcA, E_SrcB, D_MD_Use,
    output MD_Busy, MD_Stall, HI, LO
  );
endinterface

// File: rtl/md_scheduler.sv
// Fixed-latency mult/div scheduler with architectural HI/LO and pipeline stall.
// Define MD_SCHEDULER_DIV0_GUARD_EN to turn a zero-divisor div/divu into a no-op.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  md_scheduler_if.slave md
);
  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [3:0] MULT_N   = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N    = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] shi_q, shi_d, slo_q, slo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [31:0] a, b;
  logic [63:0] prod_s, prod_u;
  logic        div_signed, neg_a, neg_b, b_zero;
  logic [31:0] mag_a, mag_b, mag_b_safe, q_mag, r_mag, div_hi, div_lo;
  logic        busy, md_op;

  assign a = md.E_SrcA;
  assign b = md.E_SrcB;

  // Low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. Also keeps -2^31 / -1 well defined.
  assign div_signed = (md.E_MD_Op == OP_DIV);
  assign neg_a      = div_signed & a[31];
  assign neg_b      = div_signed & b[31];
  assign mag_a      = neg_a ? -a : a;
  assign mag_b      = neg_b ? -b : b;
  assign b_zero     = (b == 32'd0);
  assign mag_b_safe = b_zero ? 32'd1 : mag_b;
  assign q_mag      = mag_a / mag_b_safe;
  assign r_mag      = mag_a % mag_b_safe;
  assign div_lo     = b_zero ? 32'hFFFF_FFFF : ((neg_a ^ neg_b) ? -q_mag : q_mag);
  assign div_hi     = b_zero ? a : (neg_a ? -r_mag : r_mag);

  assign busy  = (state_q != IDLE);
  assign md_op = (md.E_MD_Op >= OP_MULT) && (md.E_MD_Op <= OP_DIVU);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (md.E_Start) begin
          case (md.E_MD_Op)
            OP_MULT, OP_MULTU: begin
              {shi_d, slo_d} = (md.E_MD_Op == OP_MULT) ? prod_s : prod_u;
              cnt_d   = MULT_N;
              state_d = MULT;
            end
            OP_DIV, OP_DIVU: begin
`ifdef MD_SCHEDULER_DIV0_GUARD_EN
              if (!b_zero) begin
                shi_d   = div_hi;
                slo_d   = div_lo;
                cnt_d   = DIV_N;
                state_d = DIV;
              end
`else
              shi_d   = div_hi;
              slo_d   = div_lo;
              cnt_d   = DIV_N;
              state_d = DIV;
`endif
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MULT, DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = shi_q;
          lo_d    = slo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      shi_q   <= 32'd0;
      slo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.MD_Busy  = busy;
  assign md.MD_Stall = md.D_MD_Use & (busy | (md.E_Start & md_op));
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed scenarios plus random traffic
// against a timestamp-based reference model of HI/LO and the busy window.
module tb_md_scheduler;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  md_scheduler_if mif ();

  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: an accepted op finishes at edge m_done; busy while m_edge < m_done.
  int          m_edge = 0;
  int          m_done = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, m_edge);
    end
  endtask

  task automatic step(input bit rst, input bit st, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input bit use_d);
    bit      busy_now;
    longint  sa, sb, pr;
    longint unsigned ua, ub, pu;
    reset        = rst;
    mif.E_Start  = st;
    mif.E_MD_Op  = op;
    mif.E_SrcA   = a;
    mif.E_SrcB   = b;
    mif.D_MD_Use = use_d;
    #1;
    busy_now = (m_edge < m_done);
    chk("stall", {31'b0, mif.MD_Stall},
        {31'b0, use_d & (busy_now | (st & (op >= 3'd1) & (op <= 3'd4)))});
    @(posedge clk);
    m_edge++;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (rst) begin
      m_done = m_edge;
      m_hi = '0; m_lo = '0;
    end else begin
      if (busy_now && m_edge == m_done) begin
        m_hi = p_hi; m_lo = p_lo;
      end
      if (!busy_now && st) begin
        case (op)
          3'd1: begin pr = sa * sb; {p_hi, p_lo} = pr; m_done = m_edge + MC; end
          3'd2: begin pu = ua * ub; {p_hi, p_lo} = pu; m_done = m_edge + MC; end
          3'd3, 3'd4: begin
            if (b == 0) begin
`ifdef MD_SCHEDULER_DIV0_GUARD_EN
              ;
`else
              p_hi = a; p_lo = 32'hFFFF_FFFF; m_done = m_edge + DC;
`endif
            end else if (op == 3'd3) begin
              p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); m_done = m_edge + DC;
            end else begin
              p_lo = 32'(ua / ub); p_hi = 32'(ua % ub); m_done = m_edge + DC;
            end
          end
          3'd5: m_hi = a;
          3'd6: m_lo = a;
          default: ;
        endcase
      end
    end
    @(negedge clk);
    chk("busy", {31'b0, mif.MD_Busy}, {31'b0, m_edge < m_done});
    chk("hi", mif.HI, m_hi);
    chk("lo", mif.LO, m_lo);
  endtask

  task automatic idle(input int n, input bit use_d);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, $urandom, $urandom, use_d);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 5)
      0: return 32'd0;
      1: return 32'($signed($urandom_range(40)) - 20);
      2: return ($urandom % 2) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    mif.E_Start = 1'b0; mif.E_MD_Op = 3'd0; mif.E_SrcA = '0; mif.E_SrcB = '0; mif.D_MD_Use = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, 3'd0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 3'd1, 32'd3, 32'd4, 1'b0);
    chk("rst_hi", mif.HI, 32'h0);
    chk("rst_busy", {31'b0, mif.MD_Busy}, 32'h0);

    // mult 5 * -3
    step(1'b0, 1'b1, 3'd1, 32'd5, 32'hFFFF_FFFD, 1'b1);
    idle(MC, 1'b1);
    chk("s030_hi", mif.HI, 32'hFFFF_FFFF);
    chk("s030_lo", mif.LO, 32'hFFFF_FFF1);

    step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle(MC, 1'b0);
    chk("s031_hi", mif.HI, 32'hFFFF_FFFE);
    chk("s031_lo", mif.LO, 32'h0000_0001);

    step(1'b0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    idle(DC, 1'b1);
    chk("s032_lo", mif.LO, 32'hFFFF_FFFD);
    chk("s032_hi", mif.HI, 32'hFFFF_FFFF);

    step(1'b0, 1'b1, 3'd5, 32'h1234_5678, 0, 1'b1);
    chk("s033_hi", mif.HI, 32'h1234_5678);
    step(1'b0, 1'b1, 3'd6, 32'h9ABC_DEF0, 0, 1'b1);
    chk("s033_lo", mif.LO, 32'h9ABC_DEF0);

    // reset on the fourth busy cycle of a divide
    step(1'b0, 1'b1, 3'd4, 32'd100, 32'd7, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 1'b0, 3'd0, 0, 0, 1'b0);
    chk("s034_hi", mif.HI, 32'h0);
    chk("s034_lo", mif.LO, 32'h0);
    step(1'b0, 1'b1, 3'd1, 32'd6, 32'd7, 1'b0);
    idle(MC, 1'b0);
    chk("s034_mult", mif.LO, 32'd42);

    // divide by zero, plus a start ignored while busy and the reserved op
    step(1'b0, 1'b1, 3'd4, 32'hCAFE_F00D, 32'd0, 1'b1);
    step(1'b0, 1'b1, 3'd5, 32'h5555_5555, 0, 1'b1);
    idle(DC, 1'b1);
`ifdef MD_SCHEDULER_DIV0_GUARD_EN
    chk("s035_hi", mif.HI, 32'h5555_5555);
`else
    chk("s035_hi", mif.HI, 32'hCAFE_F00D);
    chk("s035_lo", mif.LO, 32'hFFFF_FFFF);
`endif
    step(1'b0, 1'b1, 3'd7, 32'h1, 32'h1, 1'b1);
    step(1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DC, 1'b0);

    for (int i = 0; i < 600; i++)
      step(($urandom % 60) == 0, ($urandom % 3) != 0, 3'($urandom), pick(), pick(), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/md_scheduler.md
MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy length of mult/multu in cycles (legal 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy length of div/divu in cycles (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port E_MD_Op  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-006 SHALL have port E_Start  input  1  E-stage instruction valid; E_MD_Op acts only when high.
REQ-007 SHALL have port E_SrcA  input  32  rs operand (dividend, multiplicand, mthi/mtlo data).
REQ-008 SHALL have port E_SrcB  input  32  rt operand (divisor, multiplier).
REQ-009 SHALL have port D_MD_Use  input  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
REQ-010 SHALL have port MD_Busy  output  1  unit is in MULT or DIV state.
REQ-011 SHALL have port MD_Stall  output  1  freeze F/D and bubble E.
REQ-012 SHALL have ports HI and LO  output  32 each  architectural HI/LO registers, read by mfhi/mflo forwarding.

Function
REQ-013 SHALL implement states IDLE, MULT, DIV, plus a 4-bit down-counter cnt.
REQ-014 In IDLE, E_Start high with op 1/2 SHALL compute the 64-bit product (signed for 1, unsigned for 2) into shadow registers, load cnt=MULT_CYCLES, and go to MULT at the same edge.
REQ-015 In IDLE, E_Start high with op 3/4 SHALL compute quotient to shadow LO and remainder to shadow HI, load cnt=DIV_CYCLES, and go to DIV.
REQ-016 Signed divide SHALL truncate toward zero; the remainder SHALL take the dividend's sign.
REQ-017 In MULT/DIV, cnt SHALL decrement each edge; on the edge where cnt goes 1->0, HI/LO SHALL load the shadow values and the state SHALL return to IDLE.
REQ-018 The latency rule is: start sampled at edge k -> MD_Busy high for exactly N cycles following edge k; HI/LO new values visible after edge k+N; N = MULT_CYCLES or DIV_CYCLES.
REQ-019 In IDLE, E_Start with op 5 (mthi) or op 6 (mtlo) SHALL write E_SrcA to HI or LO at that edge, with no busy period.
REQ-020 MD_Stall SHALL be combinational: D_MD_Use & (MD_Busy | (E_Start & E_MD_Op in 1..4)).
REQ-021 E_Start with any op while busy SHALL be ignored, with no state, counter or HI/LO change. This cannot occur when REQ-020 is honoured, but it is still required.
REQ-022 Op 0 or op 7 SHALL have no effect in any state.
REQ-023 HI/LO SHALL be constant except at the edges of REQ-017 and REQ-019.

Reset
REQ-024 reset high at a clock edge SHALL force IDLE, cnt=0, shadows=0, HI=0, LO=0, MD_Busy=0. It SHALL override any simultaneous E_Start.
REQ-025 reset asserted mid-operation SHALL abort the operation without updating HI/LO from the shadows.
REQ-026 After reset release, MD_Stall SHALL equal D_MD_Use & E_Start & (E_MD_Op in 1..4).

Configuration
REQ-027 Macro MD_SCHEDULER_DIV0_GUARD_EN SHALL select divide-by-zero behaviour.
REQ-028 With the macro defined, div/divu with E_SrcB=0 SHALL be a no-op: stay IDLE, no busy, HI/LO unchanged.
REQ-029 Without the macro, div/divu with E_SrcB=0 SHALL run the normal DIV_CYCLES busy period, then load HI=E_SrcA and LO=32'hFFFF_FFFF. No X SHALL propagate.

Verification
REQ-030 Scenario: mult, SrcA=5, SrcB=32'hFFFF_FFFD -> MD_Busy high for 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF1.
REQ-031 Scenario: multu, SrcA=SrcB=32'hFFFF_FFFF -> after 5 cycles HI=32'hFFFF_FFFE, LO=32'h0000_0001.
REQ-032 Scenario: div, SrcA=-7, SrcB=2 -> busy 10 cycles; then LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. With D_MD_Use=1 throughout, MD_Stall is high on the start cycle plus 10 cycles.
REQ-033 Scenario: mthi 32'h1234_5678, then mtlo 32'h9ABC_DEF0 on back-to-back cycles -> HI and LO update on consecutive edges; MD_Busy stays 0.
REQ-034 Scenario: start div, assert reset on busy cycle 4 -> next cycle HI=LO=0, MD_Busy=0; a following mult completes normally.
REQ-035 Scenario: divu with SrcB=0 -> with the macro, no busy period and HI/LO unchanged; without the macro, busy 10 cycles then HI=SrcA, LO=32'hFFFF_FFFF.
